instr_mem_pipelined: RTL
========================

Name: instr_mem_pipelined

Overview:
- Parametrised successor to the combinational byte-addressed instruction memory.
- Byte-addressed, big-endian word fetch with 1- or 2-cycle registered latency, a valid/ready fetch handshake, and a pipeline stall hold and flush.
- Flags misaligned and out-of-range PCs instead of returning garbage.
- Provides a word-wide program-load port so test programs load at runtime instead of only from initial blocks.
- Sits between the IF-stage PC register and the IF/ID pipeline register.

Parameters:
- ADDR_W, 32, width of fetch_pc and prog_addr.
- DEPTH_BYTES, 16384, memory size in bytes; multiple of 4.
- READ_LAT, 1, fetch latency in cycles; legal values 1 or 2.
- NOP_INSTR, 32'h00000000, word driven on fetch_instr when there is no valid data or on a fault.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  IF stage requests the word at fetch_pc.
- fetch_pc  in  ADDR_W  byte address of the request.
- fetch_ready  out  1  request accepted this cycle when fetch_req && fetch_ready.
- fetch_stall  in  1  downstream cannot take fetch_instr; hold the output.
- flush  in  1  discard all in-flight fetches (branch taken).
- fetch_valid  out  1  fetch_instr/fetch_fault hold a result.
- fetch_instr  out  32  {mem[a],mem[a+1],mem[a+2],mem[a+3]}.
- fetch_fault  out  2  bit0 misaligned (pc[1:0]!=0), bit1 out of range (pc > DEPTH_BYTES-4).
- prog_we  in  1  program-load write strobe.
- prog_addr  in  ADDR_W  byte address of the write; must be word-aligned.
- prog_wdata  in  32  big-endian word; byte 31:24 goes to mem[addr].
- prog_err  out  1  pulses for one cycle on a misaligned or out-of-range prog write; the write is dropped.

Behaviour:
- Reset (async, rst_n=0): fetch_valid=0, fetch_instr=NOP_INSTR, fetch_fault=0, prog_err=0, all pipeline valid bits cleared.
  - Memory array is not cleared by reset; contents are zero-initialised at time 0 only.
  - Reset mid-fetch drops the fetch; no result appears after rst_n rises.
- fetch_ready = !prog_we && !(fetch_valid && fetch_stall).
  - A program write always wins the cycle; fetches wait.
- Pipeline: a READ_LAT-deep valid/data shift register.
  - READ_LAT=1: result visible the cycle after acceptance.
  - READ_LAT=2: raw word is registered in stage 1; fault/valid and output are registered in stage 2.
- Throughput: one accepted fetch per cycle when unstalled, with back-to-back results.
- Stall: while fetch_valid && fetch_stall, the output registers and all stages hold their values. No new accept occurs and no entry is lost.
- Flush: all stage valid bits clear on the next edge and fetch_valid=0 the following cycle.
  - A request presented in the same cycle as flush is accepted and produces a result. It is the branch target.
  - Flush overrides stall.
- Faults are computed at acceptance.
  - Any fault bit set: fetch_instr=NOP_INSTR, and the memory is not read.
  - Both bits may be set together.
- Fetch address arithmetic: byte indices a..a+3 are computed in ADDR_W bits. A pc near 2^ADDR_W-1 is out of range, with no wrap.
- Program write: committed on the clock edge when prog_we=1 and the address is legal.
  - A fetch of the same word accepted on the next cycle returns the new data. There is no stale read.
- Fetch and prog_we in the same cycle: the fetch is not accepted (ready=0). fetch_valid for earlier in-flight fetches is unaffected.
- prog_err: registered, high for exactly one cycle per bad write. Memory is unchanged.

Test Plan:
- Reset then load 0x2413000F at 600 via prog; fetch pc=600 with READ_LAT=1 -> next cycle fetch_valid=1, fetch_instr=0x2413000F, fetch_fault=0.
- Back-to-back fetches 600, 604, 608 with READ_LAT=2 -> valid results on cycles +2, +3, +4 in order. Stall asserted 1 cycle on the second result holds 604's word and delays 608 by one cycle.
- Fetch pc=602 -> fetch_fault=01, fetch_instr=0x00000000. Fetch pc=16384 -> fault=10. Fetch pc=0xFFFFFFFE -> fault=11.
- Two fetches in flight (READ_LAT=2) with flush plus a new request at pc=500 -> the in-flight results are never valid; only pc=500's word appears, 2 cycles later.
- prog_we at 0x64 concurrent with fetch_req -> fetch_ready=0 that cycle. Fetch 0x64 next cycle returns the written word. prog_addr=0x66 -> prog_err pulse, memory unchanged.
- rst_n dropped asynchronously mid-cycle with a fetch in flight -> outputs clear immediately. After release, no fetch_valid until a new request is accepted.

Source files
------------

// File: rtl/instr_mem_pipelined.sv
// Byte-addressed, big-endian instruction memory with a 1- or 2-cycle registered fetch pipeline,
// stall/flush control, PC fault flags and a word-wide program-load port.
module instr_mem_pipelined #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_BYTES = 16384,
  parameter int unsigned READ_LAT    = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_pc,
  output logic              o_fetch_ready,
  input  logic              i_fetch_stall,
  input  logic              i_flush,
  output logic              o_fetch_valid,
  output logic [31:0]       o_fetch_instr,
  output logic [1:0]        o_fetch_fault,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [31:0]       i_prog_wdata,
  output logic              o_prog_err
);

  localparam int unsigned WORDS   = DEPTH_BYTES / 4;
  localparam int unsigned IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH_BYTES - 4);

  // Word-organised storage: every legal access is word-aligned, so mem[a] is bits 31:24.
  logic [31:0] r_mem [WORDS] = '{default: 32'h0000_0000};

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [1:0]        r_fault;
  logic              r_prog_err;

  logic              w_hold;
  logic              w_accept;
  logic [1:0]        w_fault;
  logic [IDX_W-1:0]  w_fetch_idx;
  logic [31:0]       w_word;
  logic              w_prog_bad;
  logic [IDX_W-1:0]  w_prog_idx;
  logic              w_d_valid;
  logic [1:0]        w_d_fault;
  logic [31:0]       w_d_word;

  assign o_fetch_ready = !i_prog_we && !(r_valid && i_fetch_stall);
  assign w_accept      = i_fetch_req && o_fetch_ready;
  // Flush must drain the pipe even when downstream is stalled.
  assign w_hold        = r_valid && i_fetch_stall && !i_flush;

  // Out-of-range test compares in ADDR_W bits so PCs near the top never wrap into the array.
  assign w_fault[0]  = (i_fetch_pc[1:0] != 2'b00);
  assign w_fault[1]  = (i_fetch_pc > LAST_PC);
  assign w_fetch_idx = i_fetch_pc[IDX_W+1:2];
  assign w_word      = (w_fault != 2'b00) ? NOP_INSTR : r_mem[w_fetch_idx];

  assign w_prog_bad  = (i_prog_addr[1:0] != 2'b00) || (i_prog_addr > LAST_PC);
  assign w_prog_idx  = i_prog_addr[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (i_prog_we && !w_prog_bad) begin
      r_mem[w_prog_idx] <= i_prog_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prog_err <= 1'b0;
    end else begin
      r_prog_err <= i_prog_we && w_prog_bad;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic        r_s1_valid;
    logic [1:0]  r_s1_fault;
    logic [31:0] r_s1_word;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1_valid <= 1'b0;
        r_s1_fault <= 2'b00;
        r_s1_word  <= NOP_INSTR;
      end else if (!w_hold) begin
        r_s1_valid <= w_accept;
        r_s1_fault <= w_fault;
        r_s1_word  <= w_word;
      end
    end

    // The in-flight stage-1 entry dies on flush; the request accepted alongside it survives.
    assign w_d_valid = r_s1_valid && !i_flush;
    assign w_d_fault = r_s1_fault;
    assign w_d_word  = r_s1_word;
  end else begin : g_lat1
    assign w_d_valid = w_accept;
    assign w_d_fault = w_fault;
    assign w_d_word  = w_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_fault <= 2'b00;
    end else if (!w_hold) begin
      r_valid <= w_d_valid;
      r_instr <= w_d_valid ? w_d_word : NOP_INSTR;
      r_fault <= w_d_valid ? w_d_fault : 2'b00;
    end
  end

  assign o_fetch_valid = r_valid;
  assign o_fetch_instr = r_instr;
  assign o_fetch_fault = r_fault;
  assign o_prog_err    = r_prog_err;

endmodule
